tile_spawner: RTL and testbench
===============================

Name: tile_spawner

Overview:
Parametrised successor to the fixed 4-lane, fixed-period tile generator. It converts a free-running random word into a one-hot lane pattern once per spawn interval and emits a one-cycle spawn pulse. It adds run/pause/restart control and a difficulty ramp that shortens the interval as play progresses. It sits between the LFSR and the tile-scroll/display logic.

Parameters:
LANES, 4, number of lanes (2..8)
RAND_W, 3, width of random input (2**RAND_W >= LANES)
CNT_W, 26, interval counter width
PERIOD_INIT, 25000000, initial spawn interval in clk cycles (>= 2)
PERIOD_MIN, 6250000, lower clamp on interval (>= 2, <= PERIOD_INIT)
PERIOD_STEP, 1000000, interval decrement per difficulty step
STEP_EVERY, 8, spawns per difficulty step (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  game running; low = pause
restart  in  1  synchronous clear to IDLE; restart wins over en
ran  in  RAND_W  random word, sampled only on spawn cycles
lane  out  LANES  one-hot lane of current row; 0 = empty row
spawn  out  1  one-cycle pulse, coincident with lane update
period_cur  out  CNT_W  active spawn interval
level  out  8  difficulty level, saturates at 255

Behaviour:
- Reset (async, rst_n low): lane=0, spawn=0, period_cur=PERIOD_INIT, level=0, cnt=0, spawn counter=0, FSM=IDLE.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: cnt held at 0. en=1 moves to RUN and fires a spawn tick on the first RUN cycle.
  - RUN: cnt increments each cycle. Tick when cnt==period_cur-1, then cnt goes to 0. en=0 moves to PAUSE.
  - PAUSE: cnt and all outputs held, spawn=0. en=1 returns to RUN and counting resumes from the held cnt; no immediate tick.
  - restart=1 in any state: next cycle IDLE, with all state as after reset.
- Spawn tick, registered with 1-cycle latency from the tick condition:
  - spawn=1 for exactly one cycle.
  - idx=ran. If idx<LANES, lane = one-hot with bit (LANES-1-idx) set, so ran=0 gives MSB.
  - If idx>=LANES, lane=0 (gap row) and spawn still pulses.
- Interval timing: ticks are exactly period_cur cycles apart while en stays high. A pause of k cycles delays the next tick by exactly k.
- Difficulty ramp:
  - The spawn counter counts ticks, including gap rows.
  - On every STEP_EVERY-th tick, the counter clears and period_cur = max(period_cur-PERIOD_STEP, PERIOD_MIN). Subtraction must not underflow.
  - level increments only if period_cur actually decreased; it saturates at 255.
  - The new period applies from the following interval.
- lane holds its value between ticks and through PAUSE.
- ran changing between ticks has no effect.

Optional Feature:
NO_REPEAT_EN:
- Defined: a valid idx equal to the previous valid idx is rotated to (idx+1) mod LANES. This prevents the same lane appearing twice in a row. A gap row does not update the previous-idx register. The previous-idx register is cleared (invalid) by reset and restart.
- Undefined: repeats are allowed, and no previous-idx register exists.

Decomposition:
- Package tile_pkg holds:
  - FSM state enum (IDLE/RUN/PAUSE)
  - a function idx_to_onehot(idx, LANES)
  - localparam LEVEL_MAX=255
- One sub-module, spawn_timer, is natural. It contains the cnt/period_cur/level ramp, outputs a tick, and takes en/restart as inputs.
- tile_spawner contains the FSM, lane mapping and no-repeat logic.

Test Plan:
All scenarios use LANES=4, RAND_W=3, PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=3, STEP_EVERY=2.
1. Reset, en=1, ran=2 held -> first spawn 1 cycle after entering RUN with lane=0010; further spawns every 10 cycles.
2. en=1 for 6 spawns -> period_cur 10,7,4,4 after spawns 2,4,6; level 0→1→2, stays 2.
3. ran=5 on a tick -> spawn=1, lane=0000; spawn counter still advances.
4. en=0 for 3 cycles mid-interval -> next spawn exactly 13 cycles after the previous one; lane unchanged during pause.
5. restart=1 with en=1 mid-run, level=2 -> next cycle IDLE, period_cur=10, level=0, lane=0. Deasserting restart gives an immediate first spawn. Asserting rst_n=0 asynchronously mid-interval clears outputs without waiting for clk.
6. NO_REPEAT_EN defined, ran=1 on two consecutive ticks -> lane 0100 then 0010. Without the macro -> 0100 then 0100.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile spawner: FSM state encoding and lane one-hot mapping.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam int LEVEL_MAX = 255;

  // idx 0 maps to the MSB lane; out-of-range indices give an empty (gap) row.
  function automatic logic [7:0] idx_to_onehot(input int idx, input int lanes);
    logic [7:0] oh;
    oh = '0;
    if (idx >= 0 && idx < lanes) oh = 8'(1) << (lanes - 1 - idx);
    return oh;
  endfunction

endpackage

// File: rtl/spawn_timer.sv
// Spawn interval counter with difficulty ramp: emits a tick every period_cur active cycles
// and shortens the period every STEP_EVERY ticks down to PERIOD_MIN.
module spawn_timer
  import tile_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int PERIOD_INIT = 25000000,
  parameter int PERIOD_MIN  = 6250000,
  parameter int PERIOD_STEP = 1000000,
  parameter int STEP_EVERY  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             running,
  output logic             tick,
  output logic [CNT_W-1:0] period_cur,
  output logic [7:0]       level
);

  localparam int SC_W = $clog2(STEP_EVERY + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] headroom;
  logic [CNT_W-1:0] period_nxt;
  logic [SC_W-1:0]  step_cnt;
  logic             first_pend;
  logic             active;
  logic             step_due;

  // first_pend forces the very first tick of a run without waiting a full interval.
  assign active     = running && en && !restart;
  assign tick       = active && (first_pend || cnt == period_cur - CNT_W'(1));
  assign step_due   = (step_cnt == SC_W'(STEP_EVERY - 1));
  assign headroom   = period_cur - CNT_W'(PERIOD_MIN);
  assign period_nxt = (headroom > CNT_W'(PERIOD_STEP)) ? period_cur - CNT_W'(PERIOD_STEP)
                                                        : CNT_W'(PERIOD_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_cur <= CNT_W'(PERIOD_INIT);
      level      <= '0;
      step_cnt   <= '0;
      first_pend <= 1'b1;
    end else if (restart) begin
      cnt        <= '0;
      period_cur <= CNT_W'(PERIOD_INIT);
      level      <= '0;
      step_cnt   <= '0;
      first_pend <= 1'b1;
    end else if (tick) begin
      cnt        <= '0;
      first_pend <= 1'b0;
      if (step_due) begin
        step_cnt   <= '0;
        period_cur <= period_nxt;
        if (period_nxt != period_cur && level != 8'(LEVEL_MAX)) level <= level + 8'd1;
      end else begin
        step_cnt <= step_cnt + SC_W'(1);
      end
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tile_spawner.sv
// Run/pause/restart FSM that turns a random word into a one-hot lane pattern on each spawn tick.
// Optional macro NO_REPEAT_EN rotates a valid lane that would repeat the previous valid lane.
module tile_spawner
  import tile_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int RAND_W      = 3,
  parameter int CNT_W       = 26,
  parameter int PERIOD_INIT = 25000000,
  parameter int PERIOD_MIN  = 6250000,
  parameter int PERIOD_STEP = 1000000,
  parameter int STEP_EVERY  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic [RAND_W-1:0] ran,
  output logic [LANES-1:0]  lane,
  output logic              spawn,
  output logic [CNT_W-1:0]  period_cur,
  output logic [7:0]        level
);

  state_t state;
  logic   running;
  logic   tick_p0;
  int     idx_p0;

  assign running = (state != IDLE);

  spawn_timer #(
    .CNT_W      (CNT_W),
    .PERIOD_INIT(PERIOD_INIT),
    .PERIOD_MIN (PERIOD_MIN),
    .PERIOD_STEP(PERIOD_STEP),
    .STEP_EVERY (STEP_EVERY)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .running   (running),
    .tick      (tick_p0),
    .period_cur(period_cur),
    .level     (level)
  );

`ifdef NO_REPEAT_EN
  logic [RAND_W-1:0] prev_idx;
  logic              prev_vld;

  always_comb begin
    idx_p0 = int'(ran);
    if (prev_vld && idx_p0 < LANES && ran == prev_idx)
      idx_p0 = (idx_p0 + 1 == LANES) ? 0 : idx_p0 + 1;
  end

  // Gap rows leave the previous-lane memory untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      prev_idx <= '0;
    end else if (restart) begin
      prev_vld <= 1'b0;
      prev_idx <= '0;
    end else if (tick_p0 && int'(ran) < LANES) begin
      prev_vld <= 1'b1;
      prev_idx <= RAND_W'(idx_p0);
    end
  end
`else
  assign idx_p0 = int'(ran);
`endif

  // Stage p0 -> p1: tick and lane mapping registered into spawn/lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lane  <= '0;
      spawn <= 1'b0;
    end else if (restart) begin
      state <= IDLE;
      lane  <= '0;
      spawn <= 1'b0;
    end else begin
      spawn <= tick_p0;
      if (tick_p0) lane <= LANES'(idx_to_onehot(idx_p0, LANES));
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= PAUSE;
        PAUSE:   if (en) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner with LANES=4, PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=3, STEP_EVERY=2.
module tb_tile_spawner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic [2:0] ran;
  logic [3:0] lane;
  logic       spawn;
  logic [7:0] period_cur;
  logic [7:0] level;

  int n_asserts = 0;
  int n_fail    = 0;
  int gap;

  tile_spawner #(
    .LANES      (4),
    .RAND_W     (3),
    .CNT_W      (8),
    .PERIOD_INIT(10),
    .PERIOD_MIN (4),
    .PERIOD_STEP(3),
    .STEP_EVERY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .ran       (ran),
    .lane      (lane),
    .spawn     (spawn),
    .period_cur(period_cur),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_spawn(input int limit, output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (spawn !== 1'b1 && g < limit);
  endtask

  task automatic check_row(input string tag, input int g_exp, input int g_obs,
                           input logic [3:0] lane_exp, input int per_exp, input int lvl_exp);
    check({tag, "_gap"}, g_obs, g_exp);
    check({tag, "_spawn"}, spawn, 1'b1);
    check({tag, "_lane"}, lane, lane_exp);
    check({tag, "_period"}, period_cur, per_exp);
    check({tag, "_level"}, level, lvl_exp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; ran = 3'd0;
    step(); step();
    check("rst_lane", lane, 4'b0000);
    check("rst_spawn", spawn, 1'b0);
    check("rst_period", period_cur, 10);
    check("rst_level", level, 0);

    rst_n = 1'b1;
    repeat (3) step();
    check("idle_no_spawn", spawn, 1'b0);

    // First spawn one cycle after entering RUN, then every 10 cycles.
    ran = 3'd2; en = 1'b1;
    step();
    check("enter_run_spawn", spawn, 1'b0);
    step();
    check("s1_spawn", spawn, 1'b1);
    check("s1_lane", lane, 4'b0010);
    check("s1_period", period_cur, 10);
    check("s1_level", level, 0);
    step();
    check("s1_pulse_width", spawn, 1'b0);
    check("s1_lane_hold", lane, 4'b0010);

    wait_spawn(30, gap);
`ifdef NO_REPEAT_EN
    check_row("s2", 9, gap, 4'b0001, 7, 1);
`else
    check_row("s2", 9, gap, 4'b0010, 7, 1);
`endif

    ran = 3'd5;
    wait_spawn(30, gap);
    check_row("s3_gaprow", 7, gap, 4'b0000, 7, 1);

    ran = 3'd1;
    wait_spawn(30, gap);
    check_row("s4", 7, gap, 4'b0100, 4, 2);

    wait_spawn(30, gap);
`ifdef NO_REPEAT_EN
    check_row("s5_repeat", 4, gap, 4'b0010, 4, 2);
`else
    check_row("s5_repeat", 4, gap, 4'b0100, 4, 2);
`endif

    ran = 3'd3;
    wait_spawn(30, gap);
    check_row("s6_clamp", 4, gap, 4'b0001, 4, 2);

    // Three-cycle pause after one counted cycle stretches the 4-cycle interval to 7.
    step();
    check("s6_pulse_width", spawn, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_lane", lane, 4'b0001);
      check("pause_spawn", spawn, 1'b0);
    end
    en = 1'b1;
    wait_spawn(30, gap);
`ifdef NO_REPEAT_EN
    check_row("s7_after_pause", 3, gap, 4'b1000, 4, 2);
`else
    check_row("s7_after_pause", 3, gap, 4'b0001, 4, 2);
`endif

    step(); step();
    restart = 1'b1;
    step();
    check("restart_lane", lane, 4'b0000);
    check("restart_spawn", spawn, 1'b0);
    check("restart_period", period_cur, 10);
    check("restart_level", level, 0);

    ran = 3'd0; restart = 1'b0;
    wait_spawn(30, gap);
    check_row("s8_after_restart", 2, gap, 4'b1000, 10, 0);

    // Asynchronous reset mid-cycle while spawn is high.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_spawn", spawn, 1'b0);
    check("async_lane", lane, 4'b0000);
    check("async_period", period_cur, 10);
    #2;
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
